// File: rtl/wb_timeout_bridge.sv
// rtl/wb_timeout_bridge.sv - registered Wishbone host bridge with downstream timeout and fault capture
module wb_timeout_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    SEL_WIDTH      = 4,
    parameter int                    TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_0BAD
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [SEL_WIDTH-1:0]  wbs_sel_i,
    input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  s_wb_cyc_o,
    output logic                  s_wb_stb_o,
    output logic                  s_wb_we_o,
    output logic [SEL_WIDTH-1:0]  s_wb_sel_o,
    output logic [ADDR_WIDTH-1:0] s_wb_adr_o,
    output logic [DATA_WIDTH-1:0] s_wb_dat_o,
    input  logic                  s_wb_ack_i,
    input  logic                  s_wb_err_i,
    input  logic [DATA_WIDTH-1:0] s_wb_dat_i,
    output logic                  timeout_flag,
    output logic [ADDR_WIDTH-1:0] timeout_addr,
    input  logic                  timeout_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        R_ACK = 2'd0,
        R_ERR = 2'd1,
        R_TMO = 2'd2
    } resp_e;

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_e                state_q, state_d;
    resp_e                 kind_q, kind_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                  flag_q, flag_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic                  tmo_hit;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            kind_q  <= R_ACK;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            flag_q  <= 1'b0;
            faddr_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            flag_q  <= flag_d;
            faddr_q <= faddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        tmo_hit = 1'b0;

        case (state_q)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    req_d   = 1'b1;
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    adr_d   = wbs_adr_i;
                    wdat_d  = wbs_dat_i;
                    cnt_d   = CNT_W'(1);
                    state_d = FWD;
                end
            end
            FWD: begin
                // A slave response beats both a host abort and the terminal count.
                if (s_wb_ack_i || s_wb_err_i) begin
                    req_d   = 1'b0;
                    rdat_d  = s_wb_dat_i;
                    kind_d  = s_wb_ack_i ? R_ACK : R_ERR;
                    state_d = RESP;
                end else if (!wbs_cyc_i) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    req_d   = 1'b0;
                    rdat_d  = TIMEOUT_DATA;
                    kind_d  = R_TMO;
                    tmo_hit = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // First fault address is kept until cleared; a same-cycle clear lets the new fault load.
    always_comb begin
        flag_d  = flag_q;
        faddr_d = faddr_q;
        if (tmo_hit) begin
            flag_d = 1'b1;
            if (!flag_q || timeout_clr) begin
                faddr_d = adr_q;
            end
        end else if (timeout_clr) begin
            flag_d  = 1'b0;
            faddr_d = '0;
        end
    end

    assign s_wb_cyc_o   = req_q;
    assign s_wb_stb_o   = req_q;
    assign s_wb_we_o    = we_q;
    assign s_wb_sel_o   = sel_q;
    assign s_wb_adr_o   = adr_q;
    assign s_wb_dat_o   = wdat_q;

    // A timeout raises ack as well as err because the host ignores err.
    assign wbs_ack_o    = (state_q == RESP) && (kind_q != R_ERR);
    assign wbs_err_o    = (state_q == RESP) && (kind_q != R_ACK);
    assign wbs_dat_o    = (state_q == RESP) ? rdat_q : '0;

    assign timeout_flag = flag_q;
    assign timeout_addr = faddr_q;

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// tb/tb_wb_timeout_bridge.sv - directed self-checking bench for wb_timeout_bridge
module tb_wb_timeout_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat;
    logic        wbs_ack, wbs_err;
    logic [31:0] wbs_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic        s_ack, s_err;
    logic [31:0] s_rdat;
    logic        t_flag;
    logic [31:0] t_addr;
    logic        t_clr;

    int checks = 0;
    int errors = 0;

    wb_timeout_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .SEL_WIDTH     (4),
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_DATA  (32'hDEAD_0BAD)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (wbs_cyc),
        .wbs_stb_i   (wbs_stb),
        .wbs_we_i    (wbs_we),
        .wbs_sel_i   (wbs_sel),
        .wbs_adr_i   (wbs_adr),
        .wbs_dat_i   (wbs_dat),
        .wbs_ack_o   (wbs_ack),
        .wbs_err_o   (wbs_err),
        .wbs_dat_o   (wbs_rdat),
        .s_wb_cyc_o  (s_cyc),
        .s_wb_stb_o  (s_stb),
        .s_wb_we_o   (s_we),
        .s_wb_sel_o  (s_sel),
        .s_wb_adr_o  (s_adr),
        .s_wb_dat_o  (s_wdat),
        .s_wb_ack_i  (s_ack),
        .s_wb_err_i  (s_err),
        .s_wb_dat_i  (s_rdat),
        .timeout_flag(t_flag),
        .timeout_addr(t_addr),
        .timeout_clr (t_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wbs_cyc = 1'b1;
        wbs_stb = 1'b1;
        wbs_we  = we;
        wbs_sel = 4'hF;
        wbs_adr = adr;
        wbs_dat = dat;
    endtask

    task automatic host_idle();
        wbs_cyc = 1'b0;
        wbs_stb = 1'b0;
        wbs_we  = 1'b0;
        wbs_sel = 4'h0;
        wbs_adr = '0;
        wbs_dat = '0;
    endtask

    // Unanswered request: stb must stay high for exactly TMO cycles, then the bridge answers itself.
    task automatic run_tmo(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic clr_last, input logic [31:0] exp_addr);
        int n;
        n = 0;
        host_req(we, adr, wdat);
        for (int i = 0; i < TMO; i++) begin
            tick();
            if (s_stb === 1'b1) n++;
        end
        chk("tmo_no_early_ack", {31'd0, wbs_ack}, 32'd0);
        if (clr_last) t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        chk("tmo_stb_cycles", n, TMO);
        chk("tmo_stb_low", {31'd0, s_stb}, 32'd0);
        chk("tmo_ack", {31'd0, wbs_ack}, 32'd1);
        chk("tmo_err", {31'd0, wbs_err}, 32'd1);
        chk("tmo_data", wbs_rdat, 32'hDEAD_0BAD);
        chk("tmo_wdat_kept", s_wdat, wdat);
        chk("tmo_flag", {31'd0, t_flag}, 32'd1);
        chk("tmo_addr", t_addr, exp_addr);
        host_idle();
        tick();
        chk("tmo_ack_one_cycle", {31'd0, wbs_ack}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        s_ack = 1'b0;
        s_err = 1'b0;
        s_rdat = '0;
        t_clr = 1'b0;
        host_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, wbs_ack}, 32'd0);
        chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("rst_flag", {31'd0, t_flag}, 32'd0);
        chk("rst_addr", t_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Read, slave acks 2 cycles after stb rises
        host_req(1'b0, 32'h3000_0004, 32'd0);
        tick();
        chk("rd_stb_c1", {31'd0, s_stb}, 32'd1);
        chk("rd_cyc_c1", {31'd0, s_cyc}, 32'd1);
        chk("rd_adr", s_adr, 32'h3000_0004);
        chk("rd_sel", {28'd0, s_sel}, 32'hF);
        chk("rd_we", {31'd0, s_we}, 32'd0);
        tick();
        chk("rd_stb_c2", {31'd0, s_stb}, 32'd1);
        tick();
        chk("rd_stb_c3", {31'd0, s_stb}, 32'd1);
        chk("rd_no_ack_c3", {31'd0, wbs_ack}, 32'd0);
        s_ack  = 1'b1;
        s_rdat = 32'h1234_5678;
        tick();
        s_ack  = 1'b0;
        s_rdat = '0;
        chk("rd_ack", {31'd0, wbs_ack}, 32'd1);
        chk("rd_err", {31'd0, wbs_err}, 32'd0);
        chk("rd_data", wbs_rdat, 32'h1234_5678);
        chk("rd_stb_low", {31'd0, s_stb}, 32'd0);
        chk("rd_flag", {31'd0, t_flag}, 32'd0);
        host_idle();
        tick();
        chk("rd_ack_drop", {31'd0, wbs_ack}, 32'd0);
        chk("rd_data_zero", wbs_rdat, 32'd0);

        // Timeouts: first fault kept, clear, reload, clear coinciding with a fault
        run_tmo(32'h3000_0000, 1'b1, 32'hA5A5_5A5A, 1'b0, 32'h3000_0000);
        run_tmo(32'h3001_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h3000_0000);
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        chk("clr_flag", {31'd0, t_flag}, 32'd0);
        chk("clr_addr", t_addr, 32'd0);
        run_tmo(32'h3001_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h3001_0000);
        run_tmo(32'h3002_0000, 1'b1, 32'h0F0F_F0F0, 1'b1, 32'h3002_0000);
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        chk("clr2_flag", {31'd0, t_flag}, 32'd0);

        // Ack on the terminal-count cycle is a normal ack
        host_req(1'b0, 32'h3003_0000, 32'd0);
        for (int i = 0; i < TMO; i++) tick();
        chk("tc_stb_c16", {31'd0, s_stb}, 32'd1);
        s_ack  = 1'b1;
        s_rdat = 32'hCAFE_F00D;
        tick();
        s_ack  = 1'b0;
        s_rdat = '0;
        chk("tc_ack", {31'd0, wbs_ack}, 32'd1);
        chk("tc_err", {31'd0, wbs_err}, 32'd0);
        chk("tc_data", wbs_rdat, 32'hCAFE_F00D);
        chk("tc_flag", {31'd0, t_flag}, 32'd0);
        host_idle();
        tick();

        // Slave error on the first FWD cycle: minimum 3-cycle transaction
        host_req(1'b1, 32'h3008_0000, 32'h1111_2222);
        tick();
        s_err  = 1'b1;
        s_rdat = 32'h0BAD_F00D;
        tick();
        s_err  = 1'b0;
        s_rdat = '0;
        chk("err_ack", {31'd0, wbs_ack}, 32'd0);
        chk("err_err", {31'd0, wbs_err}, 32'd1);
        chk("err_data", wbs_rdat, 32'h0BAD_F00D);
        chk("err_flag", {31'd0, t_flag}, 32'd0);
        host_idle();
        tick();

        // Host abort at FWD cycle 5
        host_req(1'b0, 32'h3004_0000, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("ab_stb_c5", {31'd0, s_stb}, 32'd1);
        host_idle();
        tick();
        chk("ab_cyc_low", {31'd0, s_cyc}, 32'd0);
        chk("ab_stb_low", {31'd0, s_stb}, 32'd0);
        chk("ab_no_ack", {31'd0, wbs_ack}, 32'd0);
        chk("ab_no_err", {31'd0, wbs_err}, 32'd0);
        tick();
        chk("ab_no_ack2", {31'd0, wbs_ack}, 32'd0);
        chk("ab_flag", {31'd0, t_flag}, 32'd0);
        host_req(1'b0, 32'h3005_0000, 32'd0);
        tick();
        chk("ab_next_stb", {31'd0, s_stb}, 32'd1);
        chk("ab_next_adr", s_adr, 32'h3005_0000);
        s_ack  = 1'b1;
        s_rdat = 32'h0000_55AA;
        tick();
        s_ack  = 1'b0;
        s_rdat = '0;
        chk("ab_next_ack", {31'd0, wbs_ack}, 32'd1);
        chk("ab_next_data", wbs_rdat, 32'h0000_55AA);
        host_idle();
        tick();

        // Asynchronous reset between clock edges during FWD
        host_req(1'b1, 32'h3006_0000, 32'hDEAD_BEEF);
        tick();
        tick();
        chk("ar_stb_before", {31'd0, s_stb}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_cyc", {31'd0, s_cyc}, 32'd0);
        chk("ar_stb", {31'd0, s_stb}, 32'd0);
        chk("ar_adr", s_adr, 32'd0);
        chk("ar_wdat", s_wdat, 32'd0);
        chk("ar_we", {31'd0, s_we}, 32'd0);
        host_idle();
        tick();
        chk("ar_hold_ack", {31'd0, wbs_ack}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ar_after_ack", {31'd0, wbs_ack}, 32'd0);
        host_req(1'b0, 32'h3007_0000, 32'd0);
        tick();
        chk("ar_new_stb", {31'd0, s_stb}, 32'd1);
        s_ack  = 1'b1;
        s_rdat = 32'h0000_0077;
        tick();
        s_ack  = 1'b0;
        s_rdat = '0;
        chk("ar_new_ack", {31'd0, wbs_ack}, 32'd1);
        chk("ar_new_data", wbs_rdat, 32'h0000_0077);
        host_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_timeout_bridge.md
Name: wb_timeout_bridge

Overview:
- Registered Wishbone classic bridge between the Caravel host port (wbs_*) and the 27-way peripheral bus splitter.
- Forwards one transaction at a time and returns the slave response to the host.
- Aborts any transaction not acknowledged within TIMEOUT_CYCLES and answers the host itself, so an unmapped or hung peripheral cannot stall the management core.
- Latches the faulting address and raises a sticky flag for firmware diagnosis.

Parameters:
- ADDR_WIDTH, 32, address width, both sides.
- DATA_WIDTH, 32, data width, both sides.
- SEL_WIDTH, 4, byte-select width.
- TIMEOUT_CYCLES, 64, maximum cycles s_wb_stb_o stays high awaiting a response (legal range 2..65535).
- TIMEOUT_DATA, 32'hDEAD_0BAD, read data returned on a timed-out transaction.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset. Asynchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  host request.
- wbs_sel_i  in  SEL_WIDTH  host byte select.
- wbs_adr_i  in  ADDR_WIDTH  host address.
- wbs_dat_i  in  DATA_WIDTH  host write data.
- wbs_ack_o  out  1  host acknowledge.
- wbs_err_o  out  1  host error (slave err or timeout).
- wbs_dat_o  out  DATA_WIDTH  host read data.
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1 each  request to splitter.
- s_wb_sel_o  out  SEL_WIDTH  request byte select.
- s_wb_adr_o  out  ADDR_WIDTH  request address.
- s_wb_dat_o  out  DATA_WIDTH  request write data.
- s_wb_ack_i, s_wb_err_i  in  1 each  splitter response.
- s_wb_dat_i  in  DATA_WIDTH  splitter read data.
- timeout_flag  out  1  sticky timeout indicator.
- timeout_addr  out  ADDR_WIDTH  address of the first unacknowledged timeout.
- timeout_clr  in  1  synchronous clear of timeout_flag and timeout_addr.

Behaviour:
- Reset (async, wb_rst_i=1): every output 0, FSM to IDLE, counter 0. Any in-flight transaction is discarded silently, with no ack to the host.
- FSM states: IDLE, FWD, RESP.

IDLE:
- On wbs_cyc_i & wbs_stb_i, register adr/dat/sel/we into the s_wb_* outputs.
- Assert s_wb_cyc_o and s_wb_stb_o from the next cycle, and go to FWD with count=1.

FWD:
- Downstream outputs are held constant.
- Each cycle:
  - s_wb_ack_i or s_wb_err_i: capture s_wb_dat_i and the ack/err type, drop s_wb_cyc_o and s_wb_stb_o next cycle, go to RESP.
  - Else if wbs_cyc_i == 0 (host abort): drop s_wb_cyc_o and s_wb_stb_o next cycle, go to IDLE, no host response, no flag.
  - Else if count == TIMEOUT_CYCLES: drop s_wb_cyc_o and s_wb_stb_o and go to RESP with the timeout type. Set timeout_flag; load timeout_addr only if the flag was previously 0 (first fault kept).
  - Else count++.
- Priority: response > host abort > timeout. An ack arriving in the same cycle as the terminal count is a normal ack.

RESP:
- Exactly one cycle:
  - Normal ack: wbs_ack_o=1, wbs_dat_o = captured data.
  - Slave err: wbs_err_o=1, wbs_dat_o = captured data.
  - Timeout: wbs_ack_o=1 and wbs_err_o=1, wbs_dat_o=TIMEOUT_DATA. The ack is included because the Caravel host ignores err.
- Then go to IDLE. A request is not sampled in RESP.

Timing and data rules:
- Latency: request visible downstream 1 cycle after the host asserts stb. Host ack 1 cycle after the downstream ack. Minimum host transaction is 3 cycles.
- Outside RESP: wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0.
- Downstream stb is high for at most TIMEOUT_CYCLES consecutive cycles.
- Counter width is $clog2(TIMEOUT_CYCLES+1); the counter never wraps.
- timeout_clr=1:
  - Clears timeout_flag and timeout_addr next cycle.
  - If a timeout occurs in the same cycle, the set wins and the address loads.
- Writes and reads are treated identically. Write data is never modified.

Decomposition:
- No shared package needed.
- State encoding is a localparam set inside the module.
- A sub-module is not natural: single FSM plus counter, roughly 150-200 lines.

Test Plan (TIMEOUT_CYCLES=16):
- Read to a slave acking 2 cycles after stb:
  - Host stb at cycle 0 → s_wb_stb_o high cycles 1-3, s_wb_ack_i at cycle 3 with 0x12345678.
  - wbs_ack_o at cycle 4 with wbs_dat_o=0x12345678, no flag.
- Write to an unmapped slave that never acks:
  - s_wb_stb_o high for exactly 16 cycles.
  - Then wbs_ack_o=1, wbs_err_o=1, wbs_dat_o=0xDEAD0BAD.
  - timeout_flag=1, timeout_addr = host address.
- Two back-to-back timeouts at 0x3000_0000 then 0x3001_0000:
  - timeout_addr stays 0x3000_0000.
  - After timeout_clr the next timeout loads the new address.
- Ack on the 16th cycle (same as the terminal count) → normal ack with slave data, timeout_flag stays 0.
- Host drops wbs_cyc_i at FWD cycle 5 → downstream cyc/stb low next cycle, no wbs_ack_o, FSM back in IDLE.
- wb_rst_i asserted mid-FWD, between clock edges:
  - All outputs go 0 immediately.
  - After release, a new read completes normally.
